awb_gain_apply: RTL

Applies the per-channel white-balance gains produced by the AWB gain control block to the 24-bit RGB pixel stream. Gains are double-buffered and take effect only at a frame boundary. Multiplication, rounding and saturation run in a 3-stage stall-able pipeline with valid/ready handshakes on both sides. The block sits downstream of the AWB statistics/gain computation and upstream of CCM/gamma in the ISP.

---
 rtl/awb_gain_apply_pkg.sv | 22 ++
 rtl/awb_gain_apply_if.sv | 13 +
 rtl/awb_channel_mul.sv | 50 +++++
 rtl/awb_gain_apply.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/awb_gain_apply_pkg.sv
// Shared widths, fixed-point constants and pixel type for the AWB gain stage.
package isp_awb_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int GAIN_WIDTH   = 12;
    localparam int CNT_WIDTH    = 16;
    localparam int GAIN_FRAC    = 10;
    localparam int NUM_CH       = 3;
    localparam int PROD_WIDTH   = DATA_WIDTH + GAIN_WIDTH;
    // Width of (prod + half) >> GAIN_FRAC; the carry bit is kept so the sum cannot wrap.
    localparam int SCALED_WIDTH = PROD_WIDTH - GAIN_FRAC + 1;
    localparam int ROUND_HALF   = 1 << (GAIN_FRAC - 1);

    localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY = 12'h400;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] r;
        logic [DATA_WIDTH-1:0] g;
        logic [DATA_WIDTH-1:0] b;
    } rgb_pix_t;

endpackage

// File: rtl/awb_gain_apply_if.sv
// RGB pixel stream with frame markers and a valid/ready handshake.
interface awb_gain_apply_if;

    logic [3*isp_awb_pkg::DATA_WIDTH-1:0] data;
    logic                                 valid;
    logic                                 sof;
    logic                                 eof;
    logic                                 ready;

    modport master (output data, output valid, output sof, output eof, input ready);
    modport slave  (input data, input valid, input sof, input eof, output ready);

endinterface

// File: rtl/awb_channel_mul.sv
// One colour channel: multiply by a Q2.10 gain, round to nearest, saturate to 8 bits.
// Two registered stages (product, then result) that only move when adv_i is high.
module awb_channel_mul
    import isp_awb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  adv_i,
    input  logic [DATA_WIDTH-1:0] pix_i,
    input  logic [GAIN_WIDTH-1:0] gain_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  clip_o
);

    logic [PROD_WIDTH-1:0]   prod_d, prod_q;
    logic [PROD_WIDTH:0]     rounded;
    logic [SCALED_WIDTH-1:0] scaled;
    logic [DATA_WIDTH-1:0]   res_d, res_q;
    logic                    clip_d, clip_q;

    // Full-precision product; a zero gain naturally yields zero.
    always_comb begin
        prod_d = PROD_WIDTH'(pix_i) * PROD_WIDTH'(gain_i);
    end

    // Round half-up, drop the fraction, clamp anything above the 8-bit range.
    always_comb begin
        rounded = {1'b0, prod_q} + (PROD_WIDTH + 1)'(ROUND_HALF);
        scaled  = SCALED_WIDTH'(rounded >> GAIN_FRAC);
        clip_d  = |scaled[SCALED_WIDTH-1:DATA_WIDTH];
        res_d   = clip_d ? '1 : scaled[DATA_WIDTH-1:0];
    end

    // Stall-aware product and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prod_q <= '0;
            res_q  <= '0;
            clip_q <= 1'b0;
        end else if (adv_i) begin
            prod_q <= prod_d;
            res_q  <= res_d;
            clip_q <= clip_d;
        end
    end

    assign res_o  = res_q;
    assign clip_o = clip_q;

endmodule

// File: rtl/awb_gain_apply.sv
// White-balance gain application: double-buffered per-channel gains swapped at
// SOF, 3-stage stall-able multiply/round/saturate pipeline, per-frame clip count.
module awb_gain_apply
    import isp_awb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_enable_i,
    input  logic [GAIN_WIDTH-1:0] awb_gain_r_i,
    input  logic [GAIN_WIDTH-1:0] awb_gain_g_i,
    input  logic [GAIN_WIDTH-1:0] awb_gain_b_i,
    input  logic                  awb_done_i,
    awb_gain_apply_if.slave       rgb_in,
    awb_gain_apply_if.master      rgb_out,
    output logic [GAIN_WIDTH-1:0] gain_active_r_o,
    output logic [GAIN_WIDTH-1:0] gain_active_g_o,
    output logic [GAIN_WIDTH-1:0] gain_active_b_o,
    output logic [CNT_WIDTH-1:0]  clip_count_o
);

    logic adv, sof_beat;
    logic pend_valid_q, enable_active_q;
    logic s1_valid_q, s1_sof_q, s1_eof_q;
    logic s2_valid_q, s2_sof_q, s2_eof_q;
    logic out_valid_q, out_sof_q, out_eof_q;
    logic out_beat, clip_any;
    logic [CNT_WIDTH-1:0] clip_base, clip_run_d, clip_run_q, clip_count_q;

    rgb_pix_t pix_in, pix_out;
    logic [DATA_WIDTH-1:0] pix_ch[NUM_CH];
    logic [DATA_WIDTH-1:0] res_ch[NUM_CH];
    logic [GAIN_WIDTH-1:0] awb_gain[NUM_CH];
    logic [GAIN_WIDTH-1:0] act_gain[NUM_CH];
    logic [NUM_CH-1:0]     clip_ch;

    // Every stage moves together; the output register is the only place a stall originates.
    assign adv          = !out_valid_q || rgb_out.ready;
    assign rgb_in.ready = adv;
    assign sof_beat     = rgb_in.valid && rgb_in.sof && adv;

    assign pix_in      = rgb_pix_t'(rgb_in.data);
    assign pix_ch[0]   = pix_in.r;
    assign pix_ch[1]   = pix_in.g;
    assign pix_ch[2]   = pix_in.b;
    assign awb_gain[0] = awb_gain_r_i;
    assign awb_gain[1] = awb_gain_g_i;
    assign awb_gain[2] = awb_gain_b_i;

    // Pending flag and latched enable: SOF consumes the pending set, otherwise awb_done fills it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_valid_q    <= 1'b0;
            enable_active_q <= 1'b0;
        end else if (sof_beat) begin
            pend_valid_q    <= 1'b0;
            enable_active_q <= cfg_enable_i;
        end else if (awb_done_i) begin
            pend_valid_q    <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [GAIN_WIDTH-1:0] pend_q, act_q, frame_gain, s1_gain_d, s1_gain_q;
            logic [DATA_WIDTH-1:0] s1_pix_q;

            // Gain for this beat: a SOF beat already sees the gains it is about to install.
            always_comb begin
                frame_gain = act_q;
                if (awb_done_i) begin
                    frame_gain = awb_gain[gi];
                end else if (pend_valid_q) begin
                    frame_gain = pend_q;
                end
                s1_gain_d = enable_active_q ? act_q : GAIN_UNITY;
                if (sof_beat) begin
                    s1_gain_d = cfg_enable_i ? frame_gain : GAIN_UNITY;
                end
            end

            // Double buffer: capture on awb_done, promote to active on the SOF beat.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    pend_q <= GAIN_UNITY;
                    act_q  <= GAIN_UNITY;
                end else if (sof_beat) begin
                    act_q  <= frame_gain;
                end else if (awb_done_i) begin
                    pend_q <= awb_gain[gi];
                end
            end

            // S1: register the pixel channel together with its effective gain.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s1_pix_q  <= '0;
                    s1_gain_q <= '0;
                end else if (adv) begin
                    s1_pix_q  <= pix_ch[gi];
                    s1_gain_q <= s1_gain_d;
                end
            end

            awb_channel_mul u_mul (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .adv_i  (adv),
                .pix_i  (s1_pix_q),
                .gain_i (s1_gain_q),
                .res_o  (res_ch[gi]),
                .clip_o (clip_ch[gi])
            );

            assign act_gain[gi] = act_q;
        end
    endgenerate

    // Valid and frame markers ride alongside the data through all three stages.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sof_q    <= 1'b0;
            s2_eof_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else if (adv) begin
            s1_valid_q  <= rgb_in.valid;
            s1_sof_q    <= rgb_in.valid && rgb_in.sof;
            s1_eof_q    <= rgb_in.valid && rgb_in.eof;
            s2_valid_q  <= s1_valid_q;
            s2_sof_q    <= s1_sof_q;
            s2_eof_q    <= s1_eof_q;
            out_valid_q <= s2_valid_q;
            out_sof_q   <= s2_sof_q;
            out_eof_q   <= s2_eof_q;
        end
    end

    assign out_beat = out_valid_q && rgb_out.ready;
    assign clip_any = |clip_ch;

    // Running clip count: restarts on the SOF beat (which itself counts), saturates at all-ones.
    always_comb begin
        clip_base  = out_sof_q ? '0 : clip_run_q;
        clip_run_d = clip_run_q;
        if (out_beat) begin
            clip_run_d = (clip_any && (clip_base != '1)) ? clip_base + 1'b1 : clip_base;
        end
    end

    // Publish the completed frame's count on its EOF beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clip_run_q   <= '0;
            clip_count_q <= '0;
        end else begin
            clip_run_q <= clip_run_d;
            if (out_beat && out_eof_q) begin
                clip_count_q <= clip_run_d;
            end
        end
    end

    assign pix_out.r     = res_ch[0];
    assign pix_out.g     = res_ch[1];
    assign pix_out.b     = res_ch[2];
    assign rgb_out.data  = pix_out;
    assign rgb_out.valid = out_valid_q;
    assign rgb_out.sof   = out_sof_q;
    assign rgb_out.eof   = out_eof_q;

    assign gain_active_r_o = act_gain[0];
    assign gain_active_g_o = act_gain[1];
    assign gain_active_b_o = act_gain[2];
    assign clip_count_o    = clip_count_q;

endmodule
